// File: rtl/compr_reduce_sched.sv
// Reduces NSEG {status, ID} match segments to one merged segment.
// Uses one shared comparator and folds one segment per cycle.

module compr_datapath #(
    parameter int SEGWID = 10,
    parameter int IDWID  = 8
) (
    input  logic [SEGWID-1:0] a,
    input  logic [SEGWID-1:0] b,
    output logic [SEGWID-1:0] merged
);
    logic             a_valid;
    logic             b_valid;
    logic [IDWID-1:0] a_id;
    logic [IDWID-1:0] b_id;

    assign a_valid = (a[SEGWID-1 -: 2] == 2'b01);
    assign b_valid = (b[SEGWID-1 -: 2] == 2'b01);
    assign a_id    = a[IDWID-1:0];
    assign b_id    = b[IDWID-1:0];

    // Two valid segments that disagree collapse to ID 0 but stay valid.
    always_comb begin
        merged = '0;
        case ({a_valid, b_valid})
            2'b10:   merged = {2'b01, a_id};
            2'b01:   merged = {2'b01, b_id};
            2'b11:   merged = {2'b01, (a_id == b_id) ? a_id : {IDWID{1'b0}}};
            default: merged = '0;
        endcase
    end
endmodule

module compr_reduce_sched #(
    parameter int NSEG   = 8,
    parameter int SEGWID = 10,
    parameter int IDWID  = 8,
    parameter int CNTWID = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [NSEG*SEGWID-1:0] i_Segments,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [SEGWID-1:0]      o_Segment_Result,
    output logic                   o_Conflict,
    output logic [CNTWID-1:0]      o_Valid_Cnt,
    output logic [1:0]             o_State
);
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [NSEG*SEGWID-1:0] segs;
    logic [IDXW-1:0]        idx;
    logic [SEGWID-1:0]      acc;
    logic                   conflict;
    logic [CNTWID-1:0]      cnt;

    logic [SEGWID-1:0]      cur;
    logic [SEGWID-1:0]      merged;
    logic                   cur_valid;
    logic                   acc_valid;

    // The captured vector shifts down, so the segment being folded is always at the bottom.
    assign cur       = segs[SEGWID-1:0];
    assign cur_valid = (cur[SEGWID-1 -: 2] == 2'b01);
    assign acc_valid = (acc[SEGWID-1 -: 2] == 2'b01);

    compr_datapath #(
        .SEGWID (SEGWID),
        .IDWID  (IDWID)
    ) u_cmp (
        .a      (acc),
        .b      (cur),
        .merged (merged)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state    <= IDLE;
            segs     <= '0;
            idx      <= '0;
            acc      <= '0;
            conflict <= 1'b0;
            cnt      <= '0;
            o_Ready  <= 1'b1;
            o_Valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        segs     <= i_Segments;
                        idx      <= '0;
                        acc      <= '0;
                        conflict <= 1'b0;
                        cnt      <= '0;
                        o_Ready  <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= merged;
                    conflict <= conflict |
                                (acc_valid & cur_valid & (acc[IDWID-1:0] != cur[IDWID-1:0]));
                    cnt      <= cnt + CNTWID'(cur_valid);
                    segs     <= segs >> SEGWID;
                    idx      <= idx + 1'b1;
                    if (idx == IDXW'(NSEG - 1)) begin
                        o_Valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        o_Valid <= 1'b0;
                        o_Ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_Ready <= 1'b1;
                    o_Valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign o_Segment_Result = acc;
    assign o_Conflict       = conflict;
    assign o_Valid_Cnt      = cnt;
    assign o_State          = state;
endmodule

// File: tb/tb_compr_reduce_sched.sv
// Directed bench for compr_reduce_sched: driver pushes expected results,
// a negedge monitor pops them whenever a result is handed off.

module tb_compr_reduce_sched;
    localparam int NSEG   = 8;
    localparam int SEGWID = 10;
    localparam int CNTWID = 4;
    localparam int EW     = 1 + CNTWID + SEGWID;

    logic                   i_Clk;
    logic                   i_Rst_n;
    logic                   i_Valid;
    logic                   o_Ready;
    logic [NSEG*SEGWID-1:0] i_Segments;
    logic                   o_Valid;
    logic                   i_Ready;
    logic [SEGWID-1:0]      o_Segment_Result;
    logic                   o_Conflict;
    logic [CNTWID-1:0]      o_Valid_Cnt;
    logic [1:0]             o_State;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    compr_reduce_sched #(
        .NSEG   (NSEG),
        .SEGWID (SEGWID),
        .IDWID  (8),
        .CNTWID (CNTWID)
    ) dut (
        .i_Clk            (i_Clk),
        .i_Rst_n          (i_Rst_n),
        .i_Valid          (i_Valid),
        .o_Ready          (o_Ready),
        .i_Segments       (i_Segments),
        .o_Valid          (o_Valid),
        .i_Ready          (i_Ready),
        .o_Segment_Result (o_Segment_Result),
        .o_Conflict       (o_Conflict),
        .o_Valid_Cnt      (o_Valid_Cnt),
        .o_State          (o_State)
    );

    // clock / reset
    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic c, input logic [CNTWID-1:0] n,
                                              input logic [SEGWID-1:0] r);
        return {c, n, r};
    endfunction

    function automatic logic [NSEG*SEGWID-1:0] pack8(
        input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2, input logic [9:0] s3,
        input logic [9:0] s4, input logic [9:0] s5, input logic [9:0] s6, input logic [9:0] s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    // scoreboard monitor: a result transfers on the edge after a negedge with o_Valid & i_Ready
    initial begin
        forever begin
            @(negedge i_Clk);
            if (i_Rst_n && o_Valid && i_Ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0h required=none",
                             {o_Conflict, o_Valid_Cnt, o_Segment_Result});
                end else begin
                    chk("result", 32'({o_Conflict, o_Valid_Cnt, o_Segment_Result}),
                        32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver: present a request, hold it until accepted, then scramble the bus
    task automatic accept_req(input logic [NSEG*SEGWID-1:0] segs, input logic [EW-1:0] exp,
                              input bit push);
        int n = 0;
        @(negedge i_Clk);
        i_Segments = segs;
        i_Valid    = 1'b1;
        while (!o_Ready && n < 50) begin
            @(negedge i_Clk);
            n++;
        end
        if (!o_Ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        for (int k = 0; k < NSEG; k++)
            i_Segments[k*SEGWID +: SEGWID] = 10'($urandom_range(0, 1023));
        if (push) exp_q.push_back(exp);
    endtask

    task automatic check_latency();
        int n = 0;
        do begin
            @(posedge i_Clk);
            #1;
            n++;
        end while (!o_Valid && n < 20);
        chk("latency", 32'(n), 32'(NSEG));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_Ready && n < 30) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        chk("back_to_idle", 32'(o_Ready), 32'd1);
    endtask

    task automatic run_case(input logic [NSEG*SEGWID-1:0] segs, input logic [EW-1:0] exp);
        accept_req(segs, exp, 1'b1);
        check_latency();
        wait_idle();
    endtask

    initial begin
        i_Rst_n    = 1'b0;
        i_Valid    = 1'b0;
        i_Ready    = 1'b1;
        i_Segments = '0;
        repeat (2) @(posedge i_Clk);
        #1;
        chk("rst_ready", 32'(o_Ready), 32'd1);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_result", 32'(o_Segment_Result), 32'd0);
        chk("rst_conflict", 32'(o_Conflict), 32'd0);
        chk("rst_cnt", 32'(o_Valid_Cnt), 32'd0);
        i_Rst_n = 1'b1;

        run_case(pack8(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000),
                 mk_exp(1'b0, 4'd0, 10'h000));
        run_case(pack8(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h13C, 10'h000, 10'h000),
                 mk_exp(1'b0, 4'd1, 10'h13C));
        run_case(pack8(10'h000, 10'h155, 10'h000, 10'h000, 10'h155, 10'h000, 10'h000, 10'h155),
                 mk_exp(1'b0, 4'd3, 10'h155));
        run_case(pack8(10'h000, 10'h000, 10'h111, 10'h000, 10'h000, 10'h000, 10'h122, 10'h000),
                 mk_exp(1'b1, 4'd2, 10'h100));
        run_case(pack8(10'h3AA, 10'h000, 10'h2FF, 10'h107, 10'h000, 10'h000, 10'h000, 10'h000),
                 mk_exp(1'b0, 4'd1, 10'h107));
        // conflict leaves ID 0: a later ID 0 merges cleanly, a later non-zero ID conflicts again
        run_case(pack8(10'h105, 10'h106, 10'h100, 10'h107, 10'h000, 10'h000, 10'h000, 10'h000),
                 mk_exp(1'b1, 4'd4, 10'h100));

        // backpressure: hold off for 5 cycles in DONE while a new request knocks
        i_Ready = 1'b0;
        accept_req(pack8(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h13C, 10'h000, 10'h000),
                   mk_exp(1'b0, 4'd1, 10'h13C), 1'b1);
        check_latency();
        for (int c = 0; c < 5; c++) begin
            @(negedge i_Clk);
            chk("bp_valid", 32'(o_Valid), 32'd1);
            chk("bp_ready", 32'(o_Ready), 32'd0);
            chk("bp_result", 32'(o_Segment_Result), 32'h13C);
            chk("bp_conflict", 32'(o_Conflict), 32'd0);
            chk("bp_cnt", 32'(o_Valid_Cnt), 32'd1);
            i_Valid    = 1'b1;
            i_Segments = pack8(10'h155, 10'h155, 10'h000, 10'h000,
                               10'h000, 10'h000, 10'h000, 10'h000);
        end
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        @(posedge i_Clk);
        #1;
        chk("bp_release_ready", 32'(o_Ready), 32'd1);
        chk("bp_release_valid", 32'(o_Valid), 32'd0);
        repeat (12) @(posedge i_Clk);
        #1;
        chk("bp_no_extra_accept", 32'(o_Valid), 32'd0);
        chk("bp_idle_ready", 32'(o_Ready), 32'd1);

        // reset on the edge that would fold idx==3
        accept_req(pack8(10'h000, 10'h111, 10'h122, 10'h133, 10'h000, 10'h000, 10'h000, 10'h000),
                   mk_exp(1'b0, 4'd0, 10'h000), 1'b0);
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst_n = 1'b0;
        @(posedge i_Clk);
        #1;
        i_Rst_n = 1'b1;
        chk("midrun_rst_ready", 32'(o_Ready), 32'd1);
        chk("midrun_rst_valid", 32'(o_Valid), 32'd0);
        chk("midrun_rst_result", 32'(o_Segment_Result), 32'd0);
        chk("midrun_rst_conflict", 32'(o_Conflict), 32'd0);
        chk("midrun_rst_cnt", 32'(o_Valid_Cnt), 32'd0);
        repeat (15) @(posedge i_Clk);
        #1;
        chk("midrun_no_result", 32'(o_Valid), 32'd0);

        run_case(pack8(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h1AB),
                 mk_exp(1'b0, 4'd1, 10'h1AB));

        repeat (4) @(posedge i_Clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/compr_reduce_sched.md
Name: compr_reduce_sched

Overview:
- Sequential scheduler that reduces NSEG match segments to one result segment, using a single shared compr_datapath comparator instance.
- Each segment is {status[1:0], ID[IDWID-1:0]}; status 2'b01 means valid, any other code means invalid.
- Accepts a packed segment vector through a valid/ready handshake and folds one segment per cycle into an accumulator.
- Presents the merged segment, a conflict flag and a valid-segment count through an output valid/ready handshake.
- Sits between the TCAM sub-block match outputs and the priority/result stage.

Parameters:
- NSEG, 8: number of segments per request; must be >= 1.
- SEGWID, 10: segment width; only 10 is supported, matching the comparator's fixed bit slices.
- IDWID, 8: ID width; only 8 is supported.
- CNTWID, 4: width of o_Valid_Cnt; must satisfy 2^CNTWID > NSEG.

Ports:
- i_Clk  input  1  clock; all state changes on the rising edge.
- i_Rst_n  input  1  synchronous, active-low reset.
- i_Valid  input  1  request valid.
- o_Ready  output  1  block can accept a request.
- i_Segments  input  NSEG*SEGWID  packed segments; segment k = i_Segments[k*SEGWID +: SEGWID].
- o_Valid  output  1  result valid.
- i_Ready  input  1  downstream accepts the result.
- o_Segment_Result  output  SEGWID  merged segment.
- o_Conflict  output  1  two valid segments with different IDs were merged.
- o_Valid_Cnt  output  CNTWID  number of segments with status 2'b01.

Behaviour:
- Reset: while i_Rst_n=0 at a clock edge, the block goes to IDLE and clears all registers. Post-reset outputs: o_Ready=1, o_Valid=0, o_Segment_Result=0, o_Conflict=0, o_Valid_Cnt=0. Reset in any state, including mid-RUN or mid-DONE, abandons the request; no result is produced for it.
- State machine: IDLE, RUN, DONE.
  - IDLE: o_Ready=1. On i_Valid=1 (handshake fires):
    - capture i_Segments into an internal register;
    - acc <= 10'h000, idx <= 0, conflict <= 0, cnt <= 0;
    - go to RUN.
  - RUN: o_Ready=0. Each cycle:
    - acc <= compr_datapath(acc, seg[idx]);
    - conflict |= (acc valid & seg[idx] valid & ID mismatch);
    - cnt += seg[idx] valid;
    - idx++;
    - after the edge that processes idx==NSEG-1, go to DONE.
  - DONE: o_Valid=1; outputs driven from registered acc, conflict and cnt, held stable while i_Ready=0. On i_Ready=1: o_Valid drops on the next edge and the state returns to IDLE.
- Latency: handshake at edge E0; o_Valid is high after edge E_NSEG (NSEG cycles). Throughput is one request per NSEG+2 cycles minimum; there is no accept in DONE. NSEG=1 works with the same rules (one RUN cycle).
- Merge rules (from the comparator; the scheduler must not alter them):
  - invalid + invalid -> 10'h000;
  - one valid -> {01, valid ID};
  - both valid, same ID -> {01, ID};
  - both valid, different ID -> {01, 8'h00}, and o_Conflict is set.
  - After a conflict, acc ID is 0, so a later valid non-zero ID conflicts again; a later ID 0 merges cleanly.
- Status codes 2'b00, 2'b10 and 2'b11 are all invalid: they are not counted and not merged.
- i_Segments is sampled only at the accept edge; changes during RUN or DONE have no effect.
- i_Valid while o_Ready=0 is ignored; the requester must hold it until accepted.
- i_Ready outside DONE is ignored.
- cnt saturation cannot occur, given the CNTWID constraint.

Test Plan:
- NSEG=8, all segments 10'h000:
  - o_Valid high 8 cycles after accept;
  - result 10'h000, o_Conflict=0, o_Valid_Cnt=0.
- Only seg5={01,8'h3C}, others 10'h000 -> result 10'h13C, conflict 0, cnt 1.
- seg1, seg4, seg7 = 10'h155, others invalid -> result 10'h155, conflict 0, cnt 3.
- seg2=10'h111, seg6=10'h122 -> result 10'h100, conflict 1, cnt 2.
- Invalid status codes: seg0=10'h3AA (status 11), seg2=10'h2FF (status 10), seg3=10'h107 -> result 10'h107, cnt 1, conflict 0.
- Backpressure and reset:
  - hold i_Ready=0 for 5 cycles in DONE: outputs stable, o_Ready=0, a new i_Valid pulse is not accepted;
  - separate run: drive i_Rst_n=0 for one edge at RUN idx=3; on the next cycle o_Ready=1, o_Valid=0, all outputs 0, and no result is emitted for the abandoned request.
